// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR filter.
// Holds the scheduler state encoding, reset coefficient table and accumulator sizing.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_t;

    // Wide enough that TAPS full-scale products cannot overflow.
    function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
        return data_w + coeff_w + $clog2(taps);
    endfunction

    // Symmetric low-pass taps in Q1.15; taps beyond the table reset to zero.
    function automatic logic signed [15:0] default_coef(input int idx);
        logic signed [15:0] c;
        case (idx)
            0:       c = 16'sd1638;
            1:       c = 16'sd3277;
            2:       c = 16'sd4915;
            3:       c = 16'sd6553;
            4:       c = 16'sd6553;
            5:       c = 16'sd4915;
            6:       c = 16'sd3277;
            7:       c = 16'sd1638;
            default: c = 16'sd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
// Clear takes priority over enable.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int ACC_WIDTH   = 35
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          en,
    input  logic signed [DATA_WIDTH-1:0]  a,
    input  logic signed [COEFF_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]   acc
);

    logic signed [DATA_WIDTH+COEFF_WIDTH-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/fir_mac_sched.sv
// FIR filter sharing one multiplier across TAPS cycles per input sample.
// Define FIR_SAT_EN to clamp the result to the signed DATA_WIDTH range.
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes accepted
// MAC   | one tap product accumulated per cycle
// OUT   | result presented, held until out_ready
module fir_mac_sched
    import fir_pkg::*;
#(
    parameter int TAPS        = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int OUT_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_WIDTH-1:0]  in_sample,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          coef_we,
    input  logic [$clog2(TAPS)-1:0]       coef_addr,
    input  logic signed [COEFF_WIDTH-1:0] coef_wdata,
    output logic signed [OUT_WIDTH-1:0]   out_sample,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int AW    = $clog2(TAPS);
    localparam int ACC_W = acc_width(DATA_WIDTH, COEFF_WIDTH, TAPS);
    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

    fir_state_t state, state_nxt;

    logic signed [DATA_WIDTH-1:0]  dline [TAPS];
    logic signed [COEFF_WIDTH-1:0] coef  [TAPS];
    logic [AW-1:0] wr_ptr, rd_ptr, tap_idx;
    logic          accept;
    logic signed [ACC_W-1:0] acc, shifted, result;

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_MAC;
            ST_MAC:  if (tap_idx == LAST) state_nxt = ST_OUT;
            ST_OUT:  if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // rd_ptr walks backwards from the newest sample while tap_idx walks the coefficients.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tap_idx <= '0;
            for (int i = 0; i < TAPS; i++) dline[i] <= '0;
        end else if (accept) begin
            dline[wr_ptr] <= in_sample;
            rd_ptr        <= wr_ptr;
            wr_ptr        <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            tap_idx       <= '0;
        end else if (state == ST_MAC) begin
            rd_ptr  <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
            tap_idx <= tap_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) coef[i] <= COEFF_WIDTH'(default_coef(i));
        end else if (coef_we && (state == ST_IDLE) && (32'(coef_addr) < TAPS)) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    fir_mac #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COEFF_WIDTH (COEFF_WIDTH),
        .ACC_WIDTH   (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (state == ST_MAC),
        .a   (dline[rd_ptr]),
        .b   (coef[tap_idx]),
        .acc (acc)
    );

    // Accumulator is frozen outside MAC, so the result holds through OUT.
    assign shifted = acc >>> (COEFF_WIDTH - 1);

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        result = shifted;
        if (shifted > SAT_MAX)      result = SAT_MAX;
        else if (shifted < SAT_MIN) result = SAT_MIN;
    end
`else
    assign result = shifted;
`endif

    assign out_sample = OUT_WIDTH'(result);

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched with a reference model feeding an expected-result queue.
module tb_fir_mac_sched;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] in_sample;
    logic               in_valid;
    logic               in_ready;
    logic               coef_we;
    logic [2:0]         coef_addr;
    logic signed [15:0] coef_wdata;
    logic signed [31:0] out_sample;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    int total = 0;
    int bad   = 0;

    longint exp_q[$];
    longint m_buf  [8];
    longint m_coef [8];
    int     m_ptr;
    longint last_model;

    fir_mac_sched dut (
        .clk        (clk),
        .rst        (rst),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        longint dflt [8] = '{1638, 3277, 4915, 6553, 6553, 4915, 3277, 1638};
        for (int i = 0; i < 8; i++) begin
            m_buf[i]  = 0;
            m_coef[i] = dflt[i];
        end
        m_ptr = 0;
    endtask

    function automatic longint model_push(input longint x);
        longint acc = 0;
        longint r;
        m_buf[m_ptr] = x;
        for (int k = 0; k < 8; k++) acc += m_buf[(m_ptr - k + 8) % 8] * m_coef[k];
        m_ptr = (m_ptr + 1) % 8;
        r = acc >>> 15;
`ifdef FIR_SAT_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r;
    endfunction

    // Offers x until accepted; returns at the falling edge after the accepting clock edge.
    task automatic drive(input longint x, input bit wr, input logic [2:0] a, input logic signed [15:0] d);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        in_sample  = 16'(x);
        in_valid   = 1'b1;
        coef_we    = wr;
        coef_addr  = a;
        coef_wdata = d;
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        if (wr) m_coef[a] = longint'(d);
        last_model = model_push(x);
    endtask

    task automatic wait_output(input string tag, input int n0);
        int n = n0;
        longint e;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 8);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        check(tag, longint'(out_sample), e);
    endtask

    task automatic run(input string tag, input longint x, input bit use_const, input longint c);
        drive(x, 1'b0, 3'd0, 16'sd0);
        exp_q.push_back(use_const ? c : last_model);
        wait_output(tag, 0);
        @(negedge clk);
    endtask

    initial begin
        automatic longint imp_exp [8] = '{1637, 3276, 4914, 6552, 6552, 4914, 3276, 1637};
        longint held;
        int     hits;

        rst = 1'b1; in_sample = '0; in_valid = 1'b0; coef_we = 1'b0;
        coef_addr = '0; coef_wdata = '0; out_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sample", out_sample, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // impulse response reproduces the default coefficient table
        for (int i = 0; i < 8; i++)
            run($sformatf("impulse_%0d", i), (i == 0) ? 32767 : 0, 1'b1, imp_exp[i]);

        // DC step: partial sums via model, final value fixed
        for (int i = 0; i < 7; i++) run($sformatf("dc_%0d", i), 16384, 1'b0, 0);
        run("dc_final", 16384, 1'b1, 16383);

        // backpressure at OUT
        out_ready = 1'b0;
        drive(-12345, 1'b0, 3'd0, 16'sd0);
        exp_q.push_back(last_model);
        wait_output("hold_first", 0);
        held = longint'(out_sample);
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(out_valid && busy && !in_ready && longint'(out_sample) == held)) hits++;
        end
        check("hold_stable_cycles", hits, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_released", out_valid, 0);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        check("hold_single_output", hits, 0);

        // coefficient write during MAC is dropped
        drive(20000, 1'b0, 3'd0, 16'sd0);
        exp_q.push_back(last_model);
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'sd100;
        @(negedge clk);
        coef_we = 1'b0;
        wait_output("coef_mac_ignored", 1);
        @(negedge clk);

        // same write with accept in IDLE lands first
        drive(20000, 1'b1, 3'd0, 16'sd100);
        exp_q.push_back(last_model);
        wait_output("coef_idle_used", 0);
        @(negedge clk);

        // reset mid-MAC aborts the result and restores defaults
        drive(30000, 1'b0, 3'd0, 16'sd0);
        repeat (3) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_sample", out_sample, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        check("abort_no_stale", hits, 0);
        run("post_reset_impulse", 32767, 1'b1, 1637);

        // full-scale stress: saturates or wraps into the wider output
        for (int i = 0; i < 8; i++) begin
            coef_we = 1'b1; coef_addr = 3'(i); coef_wdata = 16'sd32767;
            @(negedge clk);
            m_coef[i] = 32767;
        end
        coef_we = 1'b0;
        for (int i = 0; i < 7; i++) run($sformatf("full_%0d", i), 32767, 1'b0, 0);
`ifdef FIR_SAT_EN
        run("full_final", 32767, 1'b1, 32767);
`else
        run("full_final", 32767, 1'b1, 262128);
`endif
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
